// File: rtl/freq_monitor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | freq_monitor_pkg: state/class encodings shared by freq_monitor.     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package freq_monitor_pkg;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    WAIT    = 3'd1,
    LOCKED  = 3'd2,
    FAULT   = 3'd3,
    STOPPED = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    IN   = 2'd1,
    OUT  = 2'd2
  } class_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/freq_monitor_hyst.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | freq_monitor_hyst: lock/fault/stopped FSM with hysteresis counters. |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module freq_monitor_hyst
  import freq_monitor_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 2
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   arm_i,
  input  logic   stb_i,
  input  class_t cls_i,
  output state_t state_o,
  output logic   change_o
);

  localparam int unsigned   CW         = $clog2(max_u(LOCK_CNT, UNLOCK_CNT) + 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_SAT    = '1;
  localparam logic [CW-1:0] CNT_LOCK   = CW'(LOCK_CNT);
  localparam logic [CW-1:0] CNT_UNLOCK = CW'(UNLOCK_CNT);

  state_t          state_q, state_d;
  logic [CW-1:0]   in_q, in_d, out_q, out_d;
  logic [CW-1:0]   in_inc, out_inc;
  logic            change_q;

  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    out_d   = out_q;
    in_inc  = (in_q == CNT_SAT) ? in_q : in_q + CNT_ONE;
    out_inc = (out_q == CNT_SAT) ? out_q : out_q + CNT_ONE;
    if (stb_i || arm_i) begin
      case (state_q)
        INIT: state_d = WAIT;
        WAIT, FAULT: begin
          if (cls_i == ZERO) begin
            state_d = STOPPED;
          end else if (cls_i == IN) begin
            in_d = in_inc;
            if (in_inc >= CNT_LOCK) state_d = LOCKED;
          end else begin
            in_d = '0;
          end
        end
        LOCKED: begin
          if (cls_i == ZERO) begin
            state_d = STOPPED;
          end else if (cls_i == OUT) begin
            out_d = out_inc;
            if (out_inc >= CNT_UNLOCK) state_d = FAULT;
          end else begin
            out_d = '0;
          end
        end
        STOPPED: begin
          // Leaving STOPPED the waking sample already counts towards lock.
          out_d = '0;
          if (cls_i == IN && CNT_ONE >= CNT_LOCK) begin
            state_d = LOCKED;
            in_d    = '0;
          end else begin
            state_d = WAIT;
            in_d    = (cls_i == IN) ? CNT_ONE : '0;
          end
        end
        default: state_d = INIT;
      endcase
    end
    if (state_d != state_q && state_q != STOPPED) begin
      in_d  = '0;
      out_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= INIT;
      in_q     <= '0;
      out_q    <= '0;
      change_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_q     <= in_d;
      out_q    <= out_d;
      change_q <= (state_d != state_q);
    end
  end

  assign state_o  = state_q;
  assign change_o = change_q;

endmodule
`default_nettype wire

// File: rtl/freq_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | freq_monitor: samples the estimator once per period, qualifies it,  |
// | tracks lock status and min/max statistics.          Rev 1.0         |
// +--------------------------------------------------------------------+
module freq_monitor
  import freq_monitor_pkg::*;
#(
  parameter int unsigned  PERIOD     = 1000,
  parameter int unsigned  FACTOR     = 2,
  parameter int unsigned  FMIN       = 900,
  parameter int unsigned  FMAX       = 1100,
  parameter int unsigned  SKIP       = 2,
  parameter int unsigned  LOCK_CNT   = 4,
  parameter int unsigned  UNLOCK_CNT = 2,
  localparam int unsigned FW         = $clog2(FACTOR * PERIOD)
) (
  input  logic          reset_n,
  input  logic          clk,
  input  logic [FW-1:0] frequency,
  input  logic          stat_clr,
  output logic [2:0]    status,
  output logic          locked,
  output logic          change,
  output logic [FW-1:0] freq_last,
  output logic [FW-1:0] freq_min,
  output logic [FW-1:0] freq_max
);

  localparam int unsigned   TW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned   SW     = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam logic [TW-1:0] TMR_END = TW'(PERIOD - 1);
  localparam logic [TW-1:0] TMR_ONE = TW'(1);
  localparam logic [SW-1:0] SKIP_N  = SW'(SKIP);
  localparam logic [SW-1:0] SKIP_ONE = SW'(1);
  localparam logic [FW-1:0] FMIN_W  = FW'(FMIN);
  localparam logic [FW-1:0] FMAX_W  = FW'(FMAX);

  if (FMIN == 0 || FMIN > FMAX) begin : g_chk_fmin
    $error("freq_monitor: need 0 < FMIN <= FMAX");
  end
  if (64'(FMAX) >= (64'd1 << FW)) begin : g_chk_fmax
    $error("freq_monitor: FMAX does not fit in FW bits");
  end
  if (PERIOD == 0) begin : g_chk_period
    $error("freq_monitor: PERIOD must be > 0");
  end

  logic [TW-1:0] tmr_q, tmr_d;
  logic [SW-1:0] skip_q, skip_d;
  logic [FW-1:0] last_q, last_d, min_q, min_d, max_q, max_d;
  logic          smp_stb, skip_done, qual, arm;
  class_t        cls;
  state_t        state;

  assign smp_stb   = (tmr_q == TMR_END);
  assign skip_done = (skip_q == SKIP_N);
  assign qual      = smp_stb && skip_done;

  // The SKIP-th sample releases INIT but is itself discarded.
  if (SKIP > 0) begin : g_arm
    assign arm = smp_stb && (skip_q == SKIP_N - SKIP_ONE);
  end else begin : g_no_arm
    assign arm = 1'b0;
  end

  always_comb begin
    if (frequency == '0)                               cls = ZERO;
    else if (frequency >= FMIN_W && frequency <= FMAX_W) cls = IN;
    else                                               cls = OUT;
  end

  always_comb begin
    tmr_d  = smp_stb ? '0 : tmr_q + TMR_ONE;
    skip_d = (smp_stb && !skip_done) ? skip_q + SKIP_ONE : skip_q;
    last_d = smp_stb ? frequency : last_q;
    min_d  = min_q;
    max_d  = max_q;
    if (qual) begin
      if (stat_clr) begin
        min_d = frequency;
        max_d = frequency;
      end else begin
        if (frequency < min_q) min_d = frequency;
        if (frequency > max_q) max_d = frequency;
      end
    end else if (stat_clr) begin
      min_d = '1;
      max_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr_q  <= '0;
      skip_q <= '0;
      last_q <= '0;
      min_q  <= '1;
      max_q  <= '0;
    end else begin
      tmr_q  <= tmr_d;
      skip_q <= skip_d;
      last_q <= last_d;
      min_q  <= min_d;
      max_q  <= max_d;
    end
  end

  freq_monitor_hyst #(
    .LOCK_CNT  (LOCK_CNT),
    .UNLOCK_CNT(UNLOCK_CNT)
  ) u_hyst (
    .clk     (clk),
    .reset_n (reset_n),
    .arm_i   (arm),
    .stb_i   (qual),
    .cls_i   (cls),
    .state_o (state),
    .change_o(change)
  );

  assign status    = state;
  assign locked    = (state == LOCKED);
  assign freq_last = last_q;
  assign freq_min  = min_q;
  assign freq_max  = max_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_monitor.sv
`default_nettype none
// Randomised self-checking bench for freq_monitor against a history-based
// behavioural model, plus directed scenarios with literal expectations.
module tb_freq_monitor;

  localparam int PERIOD = 100;
  localparam int FMIN   = 90;
  localparam int FMAX   = 110;
  localparam int SKIP   = 2;
  localparam int LOCK   = 3;
  localparam int UNLOCK = 2;

  localparam int S_INIT = 0, S_WAIT = 1, S_LOCKED = 2, S_FAULT = 3, S_STOP = 4;
  localparam int C_ZERO = 0, C_IN = 1, C_OUT = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] frequency = 8'd0;
  logic       stat_clr = 1'b0;
  logic [2:0] status;
  logic       locked, change;
  logic [7:0] freq_last, freq_min, freq_max;

  int  nvec = 0;
  int  nfail = 0;
  bit  chk_on = 1'b0;
  bit  noise_clr = 1'b0;

  freq_monitor #(
    .PERIOD(PERIOD), .FACTOR(2), .FMIN(FMIN), .FMAX(FMAX),
    .SKIP(SKIP), .LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK)
  ) dut (
    .reset_n  (reset_n),
    .clk      (clk),
    .frequency(frequency),
    .stat_clr (stat_clr),
    .status   (status),
    .locked   (locked),
    .change   (change),
    .freq_last(freq_last),
    .freq_min (freq_min),
    .freq_max (freq_max)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int         m_k, m_n, m_st;
  bit         m_chg;
  logic [7:0] m_last, m_min, m_max;
  int         hist[$];   // classes seen since entering the current state

  function automatic int trail(input int c);
    int n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != c) break;
      n++;
    end
    return n;
  endfunction

  function automatic void enter(input int s);
    m_st = s;
    hist.delete();
  endfunction

  function automatic void model_sample(input logic [7:0] f, input bit clr);
    int c;
    m_n++;
    m_last = f;
    if (m_n <= SKIP) begin
      if (clr) begin m_min = 8'hff; m_max = 8'h00; end
      if (m_n == SKIP) enter(S_WAIT);
      return;
    end
    if (clr) begin
      m_min = f; m_max = f;
    end else begin
      if (f < m_min) m_min = f;
      if (f > m_max) m_max = f;
    end
    c = (f == 0) ? C_ZERO : ((f >= FMIN && f <= FMAX) ? C_IN : C_OUT);
    case (m_st)
      S_WAIT, S_FAULT: begin
        if (c == C_ZERO) enter(S_STOP);
        else begin
          hist.push_back(c);
          if (trail(C_IN) >= LOCK) enter(S_LOCKED);
        end
      end
      S_LOCKED: begin
        if (c == C_ZERO) enter(S_STOP);
        else begin
          hist.push_back(c);
          if (trail(C_OUT) >= UNLOCK) enter(S_FAULT);
        end
      end
      S_STOP: begin
        enter(S_WAIT);
        if (c == C_IN) begin
          hist.push_back(c);
          if (trail(C_IN) >= LOCK) enter(S_LOCKED);
        end
      end
      default: enter(S_WAIT);
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    int prev;
    if (!reset_n) begin
      m_k = 0; m_n = 0; m_st = S_INIT; m_chg = 1'b0;
      m_last = 8'h00; m_min = 8'hff; m_max = 8'h00;
      hist.delete();
    end else begin
      prev = m_st;
      if (m_k % PERIOD == PERIOD - 1) model_sample(frequency, stat_clr);
      else if (stat_clr) begin m_min = 8'hff; m_max = 8'h00; end
      m_k++;
      m_chg = (m_st != prev);
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("status",    32'(status),    32'(m_st));
      check("locked",    32'(locked),    32'(m_st == S_LOCKED));
      check("change",    32'(change),    32'(m_chg));
      check("freq_last", 32'(freq_last), 32'(m_last));
      check("freq_min",  32'(freq_min),  32'(m_min));
      check("freq_max",  32'(freq_max),  32'(m_max));
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_status"}, 32'(status),    0);
    check({tag, "_locked"}, 32'(locked),    0);
    check({tag, "_change"}, 32'(change),    0);
    check({tag, "_last"},   32'(freq_last), 0);
    check({tag, "_min"},    32'(freq_min),  255);
    check({tag, "_max"},    32'(freq_max),  0);
  endtask

  // Present f (and clr) exactly in the sampling cycle; other cycles carry noise.
  task automatic do_sample(input logic [7:0] f, input bit clr);
    int guard = 0;
    @(negedge clk);
    while (m_k % PERIOD != PERIOD - 1) begin
      frequency = 8'($urandom);
      stat_clr  = noise_clr && ($urandom_range(0, 49) == 0);
      @(negedge clk);
      guard++;
      if (guard > PERIOD + 2) begin
        nfail++;
        $display("FAIL sample_timeout: no sampling slot within %0d cycles", guard);
        $fatal(1, "sampling slot not found");
      end
    end
    frequency = f;
    stat_clr  = clr;
    @(negedge clk);
    stat_clr  = 1'b0;
    frequency = 8'($urandom);
  endtask

  task automatic samples(input int n, input logic [7:0] f);
    for (int i = 0; i < n; i++) do_sample(f, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk_on = 1'b1;
    check_reset_vals("por");
    @(negedge clk);
    reset_n = 1'b1;

    // start-up: skip two, lock after the fifth
    samples(2, 8'd100);
    check("skip_status", 32'(status), 1);
    check("skip_min",    32'(freq_min), 255);
    samples(3, 8'd100);
    check("lock_status", 32'(status), 2);
    check("lock_change", 32'(change), 1);
    check("lock_min",    32'(freq_min), 100);
    check("lock_max",    32'(freq_max), 100);

    // hysteresis on unlock
    do_sample(8'd120, 1'b0);
    do_sample(8'd100, 1'b0);
    do_sample(8'd120, 1'b0);
    check("hyst_status", 32'(status), 2);
    do_sample(8'd120, 1'b0);
    check("fault_status", 32'(status), 3);
    check("fault_max",    32'(freq_max), 120);

    // relock, then a single zero sample stops immediately
    samples(3, 8'd100);
    check("relock_status", 32'(status), 2);
    do_sample(8'd0, 1'b0);
    check("stop_status", 32'(status), 4);
    check("stop_locked", 32'(locked), 0);
    check("stop_min",    32'(freq_min), 0);
    do_sample(8'd100, 1'b0);
    check("wake_status", 32'(status), 1);
    samples(2, 8'd100);
    check("wake_lock", 32'(status), 2);

    // OUT sample in WAIT restarts the lock count
    do_sample(8'd0, 1'b0);
    do_sample(8'd85, 1'b0);
    check("wait_status", 32'(status), 1);
    samples(2, 8'd100);
    do_sample(8'd85, 1'b0);
    samples(2, 8'd100);
    check("wait_nolock", 32'(status), 1);
    do_sample(8'd100, 1'b0);
    check("wait_lock", 32'(status), 2);

    // statistics clear: with a sample, then alone
    do_sample(8'd95, 1'b1);
    check("clr_smp_min", 32'(freq_min), 95);
    check("clr_smp_max", 32'(freq_max), 95);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    check("clr_min", 32'(freq_min), 255);
    check("clr_max", 32'(freq_max), 0);

    // asynchronous reset while locked
    samples(1, 8'd100);
    repeat (30) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("arst");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    samples(2, 8'd100);
    check("rst_skip_status", 32'(status), 1);
    samples(3, 8'd100);
    check("rst_lock_status", 32'(status), 2);

    // randomised traffic
    noise_clr = 1'b1;
    for (int i = 0; i < 200; i++) begin
      int r;
      logic [7:0] f;
      r = $urandom_range(0, 9);
      if (r == 0)      f = 8'd0;
      else if (r < 7)  f = 8'($urandom_range(85, 115));
      else             f = 8'($urandom);
      do_sample(f, $urandom_range(0, 7) == 0);
      if (i == 100) begin
        repeat ($urandom_range(1, 60)) @(negedge clk);
        #2 reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
      end
    end
    noise_clr = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/freq_monitor.md
Name: freq_monitor

Overview:
Downstream consumer of freq_estimator, living in the refclk domain. Samples the estimator's frequency word once per measurement period and qualifies it against a configured window. Runs a lock/fault/stopped state machine with hysteresis. Reports status, a status-change strobe and min/max statistics for CSR readout and alarm logic.

Parameters:
PERIOD, 1000, sample period in clk cycles; equals the PERIOD of the feeding freq_estimator (> 0)
FACTOR, 2, max estclk/refclk ratio; sets FW = $clog2(FACTOR*PERIOD)
FMIN, 900, lowest acceptable estimate, ticks per PERIOD (0 < FMIN <= FMAX)
FMAX, 1100, highest acceptable estimate (FMAX < 2**FW)
SKIP, 2, samples ignored after reset (start-up garbage from estimator), >= 0
LOCK_CNT, 4, consecutive in-range samples needed to lock (>= 1)
UNLOCK_CNT, 2, consecutive out-of-range samples needed to drop lock (>= 1)

Ports:
reset_n  in  1  asynchronous reset, active low
clk  in  1  clock; same as estimator refclk
frequency  in  FW  estimate from freq_estimator
stat_clr  in  1  single-cycle pulse; reinitialise min/max
status  out  3  current state code (see package)
locked  out  1  1 iff state LOCKED
change  out  1  one-cycle pulse when status changes
freq_last  out  FW  last sampled estimate
freq_min  out  FW  minimum sampled estimate since reset/clear
freq_max  out  FW  maximum sampled estimate since reset/clear

Behaviour:
- Reset (async assert, sync-released usage assumed upstream): state=INIT, status=INIT code, locked=0, change=0, freq_last=0, freq_min=all ones, freq_max=0, all counters 0. Reset mid-operation discards everything immediately.
- Sample timer: counts 0..PERIOD-1, wraps. smp_stb high in the cycle tmr==PERIOD-1. Period exactly matches the estimator, so each estimate is sampled exactly once at a fixed phase.
- On smp_stb: freq_last<=frequency. Class: ZERO if f==0; IN if FMIN<=f<=FMAX; otherwise OUT. All outputs update one cycle after smp_stb.
- Skip counter: while fewer than SKIP samples taken, state stays INIT and min/max are not updated. freq_last is still updated.
- FSM, evaluated only on a qualifying smp_stb:
  INIT -> WAIT after SKIP samples; the SKIP-th sample itself is ignored.
  WAIT: IN increments in_cnt. in_cnt reaching LOCK_CNT -> LOCKED. OUT clears in_cnt. ZERO -> STOPPED.
  LOCKED: OUT increments out_cnt. out_cnt reaching UNLOCK_CNT -> FAULT. IN clears out_cnt. ZERO -> STOPPED immediately, with no hysteresis.
  FAULT: same lock rule as WAIT -> LOCKED. ZERO -> STOPPED.
  STOPPED: IN or OUT -> WAIT with in_cnt cleared. The first IN sample counts, so in_cnt=1.
- Counters: in_cnt and out_cnt saturate, are cleared on every state change, and are sized $clog2(max(LOCK_CNT,UNLOCK_CNT)+1).
- change: 1 for exactly one cycle when the registered state differs from the previous one. It does not pulse on reset.
- Min/max: update on each post-skip sample, including ZERO samples. Unsigned compare.
  stat_clr alone sets min=all ones, max=0.
  stat_clr coincident with a sample update: min=max=sampled value (clear wins, then load).
- No arithmetic overflow: all compares are on FW bits. Parameters are checked by elaboration-time assertions (FMIN<=FMAX, FMAX<2**FW, PERIOD>0).

Decomposition:
- Package freq_monitor_pkg: enum state_t with codes INIT=3'd0, WAIT=3'd1, LOCKED=3'd2, FAULT=3'd3, STOPPED=3'd4, and class enum {ZERO, IN, OUT}.
- One natural sub-module: freq_monitor_hyst. It holds the FSM plus the in/out counters and takes class + strobe as inputs. The timer, sampling and min/max stay in the top.

Test Plan (PERIOD=100, FACTOR=2 -> FW=8, FMIN=90, FMAX=110, SKIP=2, LOCK_CNT=3, UNLOCK_CNT=2):
- Reset, frequency held at 100 -> INIT for 2 samples, WAIT at sample 3, LOCKED one cycle after sample 5. change pulses twice; min=max=100.
- Locked, then samples 120, 100, 120, 120 -> stays LOCKED through 120/100/120. FAULT after the 4th sample; max=120.
- Locked, frequency=0 for one sample -> STOPPED next cycle, locked=0, min=0. Then 100,100,100 -> WAIT, then LOCKED after the 3rd.
- WAIT, samples 100, 100, 85, 100, 100, 100 -> the OUT sample resets in_cnt. LOCKED only after the 6th sample.
- stat_clr pulsed in the smp_stb cycle with f=95 -> min=max=95. stat_clr in a non-sample cycle -> min=255, max=0.
- reset_n asserted mid-period while LOCKED -> all outputs return to reset values asynchronously. change=0; full SKIP/LOCK sequence repeats.
